// File: rtl/microwave_cook_timer.sv
// Cook-time countdown for the microwave controller: editable mm:ss time, 1 s countdown
// while heating, one-cycle timerEnd pulse at 00:00, and BCD digits for the display mux.
module microwave_cook_timer #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int MAX_MIN  = 99,
  parameter int SEC_STEP = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        idle,
  input  logic        btn_add_min,
  input  logic        btn_add_sec,
  input  logic        btn_clear,
  output logic        timerEnd,
  output logic        running,
  output logic [6:0]  minutes,
  output logic [5:0]  seconds,
  output logic [15:0] bcd_digits
);

  localparam int            PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [6:0]    MIN_CAP    = 7'(MAX_MIN);

  typedef enum logic [1:0] {S_SET, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t        r_state, w_stateNext;
  logic [PW-1:0] r_presc, w_prescNext;
  logic [6:0]    r_min, w_minNext;
  logic [5:0]    r_sec, w_secNext;
  logic          r_timerEnd, r_running;
  logic          w_timerEndNext, w_runningNext;
  logic          w_edit, w_clear, w_tick, w_timeZero, w_lastSec;
  logic [7:0]    w_addMin, w_addSec;

  // Edits are only honoured while stopped and the start/pause block reports idle.
  assign w_timeZero = (r_min == 7'd0) && (r_sec == 6'd0);
  assign w_lastSec  = (r_min == 7'd0) && (r_sec == 6'd1);
  assign w_edit     = ((r_state == S_SET) || (r_state == S_PAUSE)) && !start && idle;
  assign w_clear    = w_edit && btn_clear;
  assign w_tick     = (r_state == S_RUN) && start && (r_presc == PRESC_LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_SET;
    else     r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_SET: begin
        if (start) w_stateNext = w_timeZero ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (!start)                  w_stateNext = S_PAUSE;
        else if (w_tick && w_lastSec) w_stateNext = S_DONE;
      end
      S_PAUSE: begin
        if (start)        w_stateNext = S_RUN;
        else if (w_clear) w_stateNext = S_SET;
      end
      S_DONE:  w_stateNext = S_SET;
      default: w_stateNext = S_SET;
    endcase
  end

  // Outputs are registered from the next state so they line up exactly with RUN/DONE.
  always_comb begin
    w_runningNext  = (w_stateNext == S_RUN);
    w_timerEndNext = (w_stateNext == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_running  <= 1'b0;
      r_timerEnd <= 1'b0;
    end else begin
      r_running  <= w_runningNext;
      r_timerEnd <= w_timerEndNext;
    end
  end

  // Minutes first (saturating), then seconds with carry, then clamp to MAX_MIN:59.
  always_comb begin
    w_addMin = {1'b0, r_min};
    w_addSec = {2'b00, r_sec};
    if (btn_add_min && (r_min < MIN_CAP)) w_addMin = w_addMin + 8'd1;
    if (btn_add_sec) begin
      w_addSec = w_addSec + 8'(SEC_STEP);
      if (w_addSec >= 8'd60) begin
        w_addSec = w_addSec - 8'd60;
        w_addMin = w_addMin + 8'd1;
      end
    end
    if (w_addMin > {1'b0, MIN_CAP}) begin
      w_addMin = {1'b0, MIN_CAP};
      w_addSec = 8'd59;
    end
  end

  always_comb begin
    w_minNext   = r_min;
    w_secNext   = r_sec;
    w_prescNext = r_presc;
    if ((r_state == S_RUN) && start) begin
      if (w_tick) begin
        w_prescNext = '0;
        if (r_sec != 6'd0) begin
          w_secNext = r_sec - 6'd1;
        end else begin
          w_minNext = r_min - 7'd1;
          w_secNext = 6'd59;
        end
      end else begin
        w_prescNext = r_presc + PW'(1);
      end
    end else if (r_state == S_DONE) begin
      w_prescNext = '0;
    end else if (w_clear) begin
      w_minNext   = 7'd0;
      w_secNext   = 6'd0;
      w_prescNext = '0;
    end else if (w_edit) begin
      w_minNext = 7'(w_addMin);
      w_secNext = 6'(w_addSec);
    end
  end

  // Prescaler only moves in RUN, so a pause resumes mid-second.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_min   <= 7'd0;
      r_sec   <= 6'd0;
      r_presc <= '0;
    end else begin
      r_min   <= w_minNext;
      r_sec   <= w_secNext;
      r_presc <= w_prescNext;
    end
  end

  assign timerEnd   = r_timerEnd;
  assign running    = r_running;
  assign minutes    = r_min;
  assign seconds    = r_sec;
  assign bcd_digits = {4'(r_min / 7'd10), 4'(r_min % 7'd10),
                       4'(r_sec / 6'd10), 4'(r_sec % 6'd10)};

endmodule

// File: tb/tb_microwave_cook_timer.sv
// Bench for microwave_cook_timer: total-seconds reference model compared every cycle,
// directed scenarios with literal expectations, then randomized button/start traffic.
module tb_microwave_cook_timer;

  localparam int CLK_HZ   = 4;
  localparam int MAX_MIN  = 99;
  localparam int SEC_STEP = 10;
  localparam int MAX_TOTAL = MAX_MIN * 60 + 59;

  localparam int M_SET   = 0;
  localparam int M_HEAT  = 1;
  localparam int M_PAUSE = 2;
  localparam int M_END   = 3;

  logic        clk = 1'b0;
  logic        rst, start, idle, btn_add_min, btn_add_sec, btn_clear;
  logic        timerEnd, running;
  logic [6:0]  minutes;
  logic [5:0]  seconds;
  logic [15:0] bcd_digits;

  int assertCount = 0;
  int failCount   = 0;
  bit checkEn     = 1'b0;

  int mMode  = M_SET;
  int mTotal = 0;
  int mSub   = 0;

  microwave_cook_timer #(
    .CLK_HZ(CLK_HZ), .MAX_MIN(MAX_MIN), .SEC_STEP(SEC_STEP)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .idle(idle),
    .btn_add_min(btn_add_min), .btn_add_sec(btn_add_sec), .btn_clear(btn_clear),
    .timerEnd(timerEnd), .running(running),
    .minutes(minutes), .seconds(seconds), .bcd_digits(bcd_digits)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Edits work on total remaining seconds; a minute add only applies below the minute cap.
  task automatic modelEdit();
    if (btn_clear) begin
      mTotal = 0;
      mSub   = 0;
      if (mMode == M_PAUSE) mMode = M_SET;
    end else begin
      if (btn_add_min && (mTotal / 60 < MAX_MIN)) mTotal += 60;
      if (btn_add_sec) begin
        mTotal += SEC_STEP;
        if (mTotal > MAX_TOTAL) mTotal = MAX_TOTAL;
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      mMode = M_SET; mTotal = 0; mSub = 0;
    end else begin
      case (mMode)
        M_SET: begin
          if (start)     mMode = (mTotal == 0) ? M_END : M_HEAT;
          else if (idle) modelEdit();
        end
        M_HEAT: begin
          if (!start) mMode = M_PAUSE;
          else begin
            mSub++;
            if (mSub == CLK_HZ) begin
              mSub = 0;
              mTotal--;
              if (mTotal == 0) mMode = M_END;
            end
          end
        end
        M_PAUSE: begin
          if (start)     mMode = M_HEAT;
          else if (idle) modelEdit();
        end
        default: begin
          mSub  = 0;
          mMode = M_SET;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      int mm, ss;
      mm = mTotal / 60;
      ss = mTotal % 60;
      checkOutput("model minutes", minutes, mm);
      checkOutput("model seconds", seconds, ss);
      checkOutput("model running", running, (mMode == M_HEAT) ? 1 : 0);
      checkOutput("model timerEnd", timerEnd, (mMode == M_END) ? 1 : 0);
      checkOutput("model bcd", bcd_digits,
                  ((mm / 10) << 12) | ((mm % 10) << 8) | ((ss / 10) << 4) | (ss % 10));
    end
  end

  task automatic applyStimulus(input logic iRst, input logic iStart, input logic iIdle,
                               input logic iMin, input logic iSec, input logic iClr);
    rst = iRst; start = iStart; idle = iIdle;
    btn_add_min = iMin; btn_add_sec = iSec; btn_clear = iClr;
    @(posedge clk);
    #1;
  endtask

  task automatic runCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic stopCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic edit(input logic iMin, input logic iSec, input logic iClr);
    applyStimulus(1'b0, 1'b0, 1'b1, iMin, iSec, iClr);
  endtask

  task automatic checkTime(input string tag, input int mm, input int ss);
    checkOutput({tag, " minutes"}, minutes, mm);
    checkOutput({tag, " seconds"}, seconds, ss);
  endtask

  initial begin
    logic rStart, rIdle;
    rst = 1'b1; start = 1'b0; idle = 1'b1;
    btn_add_min = 1'b0; btn_add_sec = 1'b0; btn_clear = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkEn = 1'b1;
    checkTime("reset", 0, 0);
    checkOutput("reset running", running, 0);
    checkOutput("reset timerEnd", timerEnd, 0);

    $display("[TB] set 02:30 via buttons");
    edit(1, 0, 0); edit(1, 0, 0);
    edit(0, 1, 0); edit(0, 1, 0); edit(0, 1, 0);
    checkTime("set 02:30", 2, 30);
    checkOutput("set bcd", bcd_digits, 16'h0230);
    checkOutput("set running", running, 0);

    $display("[TB] countdown to 00:00 and end pulse");
    edit(0, 0, 1);
    edit(0, 1, 0);
    runCycles(1);
    checkOutput("start running", running, 1);
    checkTime("start", 0, 10);
    runCycles(32);
    checkTime("at 00:02", 0, 2);
    runCycles(4);
    checkTime("at 00:01", 0, 1);
    runCycles(3);
    checkTime("before end", 0, 1);
    checkOutput("before end timerEnd", timerEnd, 0);
    runCycles(1);
    checkTime("end", 0, 0);
    checkOutput("end timerEnd", timerEnd, 1);
    checkOutput("end running", running, 0);
    stopCycles(1);
    checkOutput("end pulse width", timerEnd, 0);

    $display("[TB] pause mid-second resumes the prescaler");
    edit(1, 0, 0);
    runCycles(1);
    runCycles(4);
    checkTime("first tick", 0, 59);
    runCycles(2);
    stopCycles(2);
    checkTime("paused", 0, 59);
    checkOutput("paused running", running, 0);
    runCycles(2);
    checkTime("resumed", 0, 59);
    runCycles(1);
    checkTime("resumed tick", 0, 58);
    stopCycles(1);
    edit(0, 0, 1);
    checkTime("clear in pause", 0, 0);

    $display("[TB] saturation and carry");
    for (int k = 0; k < 100; k++) edit(1, 0, 0);
    checkTime("min cap", 99, 0);
    runCycles(21);
    checkTime("98:55", 98, 55);
    stopCycles(1);
    edit(1, 0, 0);
    checkTime("99:55", 99, 55);
    edit(0, 1, 0);
    checkTime("sec cap", 99, 59);
    edit(1, 0, 0);
    checkTime("min at cap", 99, 59);
    edit(0, 0, 1);
    edit(1, 0, 0);
    runCycles(21);
    stopCycles(1);
    edit(0, 1, 0);
    checkTime("sec carry", 1, 5);
    edit(0, 0, 1);

    $display("[TB] start at 00:00 and ignored edits while running");
    runCycles(1);
    checkOutput("zero start timerEnd", timerEnd, 1);
    checkTime("zero start", 0, 0);
    stopCycles(1);
    checkOutput("zero start pulse width", timerEnd, 0);
    edit(1, 0, 0);
    runCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checkTime("edit in run", 1, 0);
    checkOutput("edit in run running", running, 1);

    $display("[TB] reset during run at 00:01");
    stopCycles(1);
    edit(0, 0, 1);
    edit(0, 1, 0);
    runCycles(37);
    checkTime("pre-reset", 0, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkTime("mid-run reset", 0, 0);
    checkOutput("mid-run reset running", running, 0);
    checkOutput("mid-run reset timerEnd", timerEnd, 0);
    stopCycles(5);
    checkOutput("no end after reset", timerEnd, 0);

    $display("[TB] randomized traffic");
    rStart = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) rStart = ~rStart;
      rIdle = rStart ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 9) != 0);
      applyStimulus($urandom_range(0, 599) == 0, rStart, rIdle,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 39) == 0);
    end

    stopCycles(2);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
